y86_fetch: RTL and testbench
============================

Name: y86_fetch

Overview:
- Fetch stage of the pipelined Y86-64 core and the producer of the 145-bit D pipeline register that the decode stage consumes.
- Selects the PC from the predicted PC, mispredicted-branch recovery or return address.
- Reads a 10-byte instruction window, splits it into fields, computes valC/valP and predicts the next PC.
- Loads D under stall/bubble control and drains to a halted state after halt or an abnormal instruction.

Parameters:
RESET_PC, 64'h0, PC fetched first after reset.
BUBBLE_ICODE, 4'h1, icode inserted into D for a bubble (nop).

Ports:
clk  in  1  clock; all state updates on posedge clk.
rst_n  in  1  reset; synchronous, active-low.
imem_addr  out  64  byte address of the fetch window; equals the selected PC f_pc (combinational).
imem_data  in  80  instruction bytes; byte0 at [7:0], byte k at [8k+7:8k]; combinational read.
imem_error  in  1  address out of range.
F_stall  in  1  hold F_predPC.
D_stall  in  1  hold D.
D_bubble  in  1  load bubble into D.
M_icode  in  4  icode in Memory stage.
M_cnd  in  1  branch condition in Memory stage.
M_valA  in  64  fall-through PC of a jXX in Memory stage.
W_icode  in  4  icode in Writeback stage.
W_valM  in  64  return address loaded by ret.
W_err  in  1  Writeback instruction is halt, invalid or memory error.
D  out  145  [144] stat_err, [143:140] icode, [139:136] ifun, [135:132] rA, [131:128] rB, [127:64] valC, [63:0] valP.
halted  out  1  sticky processor-halted flag.

Behaviour:
- Reset (rst_n=0 at posedge): F_predPC=RESET_PC; D=bubble; state=RUN; halted=0.
- Bubble value: stat_err=0, icode=BUBBLE_ICODE, ifun=0, rA=rB=4'hF, valC=0, valP=0.
- PC select, in priority order:
  - (M_icode==7 && !M_cnd) -> M_valA;
  - else W_icode==9 -> W_valM;
  - else F_predPC.
  - The result is f_pc.
- Field split:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - need_regids for icode in {2,3,4,5,6,10,11}; need_valC for {3,4,5,7,8}.
  - rA=byte1[7:4], rB=byte1[3:0] if need_regids, else 4'hF.
  - valC = bytes 2..9 if need_regids, else bytes 1..8; 0 if !need_valC.
  - valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit with wrap-around.
- Next-PC prediction: predPC = valC for icode 7 or 8 (always-taken), else valP.
- stat_err = imem_error OR icode > 11 OR icode == 0.
- F_predPC <= predPC unless F_stall, DRAIN, or HALTED; latency 1 cycle.
- D update:
  - D_bubble -> bubble; D_bubble wins over D_stall.
  - else D_stall -> hold.
  - else RUN -> fetched fields.
  - else bubble (DRAIN/HALTED).
- State machine:
  - RUN -> DRAIN when D is loaded with stat_err=1.
  - DRAIN -> RUN when a redirect is selected (mispredict or ret): that same cycle fetches from the redirect PC normally and loads D, and F_predPC updates.
  - DRAIN -> HALTED when W_err=1; if both occur, the redirect wins.
  - HALTED is sticky until reset; halted=1, imem_addr held, D bubbles.
- Reset mid-operation: everything returns to reset values at the next posedge regardless of state or stalls.

Optional Feature:
- FETCH_PERF_CNT_EN defined adds outputs perf_fetched[31:0] and perf_bubbles[31:0]:
  - perf_fetched counts D loads with a real instruction.
  - perf_bubbles counts D loads with a bubble.
  - Both counters clear on reset and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package y86_pkg holds:
  - icode constants (IHALT..IPOPQ);
  - RNONE=4'hF;
  - D field bit offsets and the D width of 145;
  - BUBBLE_D constant;
  - fetch state enum {RUN, DRAIN, HALTED}.
- Sub-module y86_fetch_align is purely combinational. It maps imem_data and f_pc to icode, ifun, rA, rB, valC, valP, need_regids, need_valC and stat_err.

Test Plan:
- Reset with RESET_PC=0x100, mem byte0=0x30 (irmovq), bytes 0xF3 + valC 0x1122334455667788 -> imem_addr=0x100; next D: icode 3, rA F, rB 3, valC 0x1122334455667788, valP 0x10A.
- jXX 0x70 at PC 0x20 with dest 0x80 -> F_predPC=0x80, D.valP=0x29; later M_icode=7, M_cnd=0, M_valA=0x29 -> imem_addr=0x29 that cycle.
- ret in W: W_icode=9, W_valM=0x400 while M holds no mispredict -> imem_addr=0x400; mispredict and ret together -> M_valA is chosen.
- D_stall=1 for 2 cycles -> D holds; D_stall=1 and D_bubble=1 -> D=bubble; F_stall=1 -> imem_addr constant.
- Halt byte 0x00 fetched -> D.stat_err=1, then bubbles; W_err=1 -> halted=1 sticky; rst_n=0 -> halted=0 and imem_addr=RESET_PC.
- Invalid icode 0xC0 and imem_error=1 each -> stat_err=1 and DRAIN; a redirect in DRAIN returns to RUN with no halt.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the fetch stage: instruction codes, the D pipeline
// register layout, the bubble value and the fetch state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int D_WIDTH     = 145;
    localparam int D_STAT_BIT  = 144;
    localparam int D_ICODE_LSB = 140;
    localparam int D_IFUN_LSB  = 136;
    localparam int D_RA_LSB    = 132;
    localparam int D_RB_LSB    = 128;
    localparam int D_VALC_LSB  = 64;
    localparam int D_VALP_LSB  = 0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [D_WIDTH-1:0] pack_d(
        input logic        stat_err,
        input logic [3:0]  icode,
        input logic [3:0]  ifun,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] val_c,
        input logic [63:0] val_p
    );
        logic [D_WIDTH-1:0] d;
        d                     = '0;
        d[D_STAT_BIT]         = stat_err;
        d[D_ICODE_LSB +: 4]   = icode;
        d[D_IFUN_LSB +: 4]    = ifun;
        d[D_RA_LSB +: 4]      = ra;
        d[D_RB_LSB +: 4]      = rb;
        d[D_VALC_LSB +: 64]   = val_c;
        d[D_VALP_LSB +: 64]   = val_p;
        return d;
    endfunction

    localparam logic [D_WIDTH-1:0] BUBBLE_D = pack_d(1'b0, INOP, 4'h0, RNONE, RNONE, 64'h0, 64'h0);

endpackage

// File: rtl/y86_fetch_align.sv
// Combinational instruction splitter: turns the 10-byte fetch window at f_pc into
// the decoded fields, the fall-through PC and the fetch status.
module y86_fetch_align
    import y86_pkg::*;
(
    input  logic [79:0] imem_data,
    input  logic [63:0] f_pc,
    input  logic        imem_error,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] val_c,
    output logic [63:0] val_p,
    output logic        need_regids,
    output logic        need_valc,
    output logic        stat_err
);

    always_comb begin
        icode       = imem_data[7:4];
        ifun        = imem_data[3:0];
        need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
        need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
        ra          = need_regids ? imem_data[15:12] : RNONE;
        rb          = need_regids ? imem_data[11:8]  : RNONE;

        // The constant word shifts by one byte when a register byte precedes it.
        if (!need_valc) begin
            val_c = 64'h0;
        end else if (need_regids) begin
            val_c = imem_data[79:16];
        end else begin
            val_c = imem_data[71:8];
        end

        val_p    = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        stat_err = imem_error || (icode > IPOPQ) || (icode == IHALT);
    end

endmodule

// File: rtl/y86_fetch.sv
// Y86-64 fetch stage: PC select, next-PC prediction and the D pipeline register.
// Define FETCH_PERF_CNT_EN to add saturating fetched/bubble load counters.
module y86_fetch
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter logic [3:0]  BUBBLE_ICODE = 4'h1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [63:0]         imem_addr,
    input  logic [79:0]         imem_data,
    input  logic                imem_error,
    input  logic                F_stall,
    input  logic                D_stall,
    input  logic                D_bubble,
    input  logic [3:0]          M_icode,
    input  logic                M_cnd,
    input  logic [63:0]         M_valA,
    input  logic [3:0]          W_icode,
    input  logic [63:0]         W_valM,
    input  logic                W_err,
    output logic [D_WIDTH-1:0]  D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles,
`endif
    output logic                halted
);

    fetch_state_e       state_q, state_d;
    logic [63:0]        f_predpc_q, f_predpc_d;
    logic [D_WIDTH-1:0] d_q, d_d;

    logic [63:0]        f_pc, pred_pc;
    logic               mispredict, ret_redirect, redirect, fetch_en;
    logic               load_fetch, load_bubble;
    logic [D_WIDTH-1:0] bubble_d, fetched_d;

    logic [3:0]         a_icode, a_ifun, a_ra, a_rb;
    logic [63:0]        a_val_c, a_val_p;
    logic               a_need_regids, a_need_valc, a_stat_err;
    logic               unused_align_flags;

    y86_fetch_align u_align (
        .imem_data   (imem_data),
        .f_pc        (f_pc),
        .imem_error  (imem_error),
        .icode       (a_icode),
        .ifun        (a_ifun),
        .ra          (a_ra),
        .rb          (a_rb),
        .val_c       (a_val_c),
        .val_p       (a_val_p),
        .need_regids (a_need_regids),
        .need_valc   (a_need_valc),
        .stat_err    (a_stat_err)
    );

    assign unused_align_flags = a_need_regids ^ a_need_valc;

    // Redirects only matter while fetching; once halted the fetch address freezes.
    always_comb begin
        mispredict   = (M_icode == IJXX) && !M_cnd;
        ret_redirect = (W_icode == IRET);
        redirect     = mispredict || ret_redirect;

        if (state_q == HALTED) begin
            f_pc = f_predpc_q;
        end else if (mispredict) begin
            f_pc = M_valA;
        end else if (ret_redirect) begin
            f_pc = W_valM;
        end else begin
            f_pc = f_predpc_q;
        end

        fetch_en = (state_q == RUN) || ((state_q == DRAIN) && redirect);
        pred_pc  = ((a_icode == IJXX) || (a_icode == ICALL)) ? a_val_c : a_val_p;

        bubble_d                      = BUBBLE_D;
        bubble_d[D_ICODE_LSB +: 4]    = BUBBLE_ICODE;
        fetched_d = pack_d(a_stat_err, a_icode, a_ifun, a_ra, a_rb, a_val_c, a_val_p);
    end

    always_comb begin
        load_fetch  = !D_bubble && !D_stall && fetch_en;
        load_bubble = D_bubble || (!D_stall && !fetch_en);

        d_d = d_q;
        if (load_bubble) begin
            d_d = bubble_d;
        end else if (load_fetch) begin
            d_d = fetched_d;
        end

        f_predpc_d = f_predpc_q;
        if (fetch_en && !F_stall) begin
            f_predpc_d = pred_pc;
        end

        // A redirect out of DRAIN can itself fetch a faulting instruction.
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (load_fetch && a_stat_err) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    state_d = (load_fetch && a_stat_err) ? DRAIN : RUN;
                end else if (W_err) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            f_predpc_q <= RESET_PC;
            d_q        <= bubble_d;
        end else begin
            state_q    <= state_d;
            f_predpc_q <= f_predpc_d;
            d_q        <= d_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (load_fetch && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (load_bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

    assign imem_addr = f_pc;
    assign D         = d_q;
    assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_y86_fetch.sv
// Scoreboard bench for y86_fetch: directed vectors push expected fetch addresses,
// D contents and halted flags; a negedge monitor retires each expectation on its cycle.
module tb_y86_fetch;

    logic         clk;
    logic         rst_n;
    logic [63:0]  imem_addr;
    logic [79:0]  imem_data;
    logic         imem_error;
    logic         F_stall, D_stall, D_bubble;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [63:0]  M_valA;
    logic [3:0]   W_icode;
    logic [63:0]  W_valM;
    logic         W_err;
    logic [144:0] D;
    logic         halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  perf_fetched, perf_bubbles;
`endif

    y86_fetch #(.RESET_PC(64'h100), .BUBBLE_ICODE(4'h1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .M_icode    (M_icode),
        .M_cnd      (M_cnd),
        .M_valA     (M_valA),
        .W_icode    (W_icode),
        .W_valM     (W_valM),
        .W_err      (W_err),
        .D          (D),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles),
`endif
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed instruction memory, 4 KiB, read combinationally.
    logic [7:0] mem [4096];

    always_comb begin
        imem_data = '0;
        for (int k = 0; k < 10; k++) begin
            imem_data[8*k +: 8] = mem[12'(imem_addr + 64'(k))];
        end
    end

    typedef struct {
        bit   rst_n;
        bit   f_stall, d_stall, d_bubble;
        logic [3:0]  m_icode;
        bit          m_cnd;
        logic [63:0] m_vala;
        logic [3:0]  w_icode;
        logic [63:0] w_valm;
        bit          w_err, imem_err;
    } stim_t;

    // kind 0 = imem_addr, 1 = D, 2 = halted
    typedef struct {
        string        name;
        int           due;
        int           kind;
        logic [144:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cycle = 0;
    int   num_checks = 0;
    int   num_fail = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.f_stall = 1'b0; s.d_stall = 1'b0; s.d_bubble = 1'b0;
        s.m_icode = 4'h0; s.m_cnd = 1'b0; s.m_vala = 64'h0;
        s.w_icode = 4'h0; s.w_valm = 64'h0; s.w_err = 1'b0; s.imem_err = 1'b0;
        return s;
    endfunction

    function automatic logic [144:0] mkD(input bit err, input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [63:0] vc, input logic [63:0] vp);
        return {err, ic, fn, ra, rb, vc, vp};
    endfunction

    function automatic logic [144:0] bubbleD();
        return mkD(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    endfunction

    function automatic logic [144:0] nopD(input logic [63:0] vp);
        return mkD(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, vp);
    endfunction

    task automatic poke(input int a, input logic [79:0] bytes, input int n);
        for (int k = 0; k < n; k++) mem[a + k] = bytes[8*k +: 8];
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        rst_n      = s.rst_n;
        F_stall    = s.f_stall;
        D_stall    = s.d_stall;
        D_bubble   = s.d_bubble;
        M_icode    = s.m_icode;
        M_cnd      = s.m_cnd;
        M_valA     = s.m_vala;
        W_icode    = s.w_icode;
        W_valM     = s.w_valm;
        W_err      = s.w_err;
        imem_error = s.imem_err;
    endtask

    task automatic expectAt(input string name, input int ofs, input int kind, input logic [144:0] v);
        exp_t e;
        e.name = name; e.due = cycle + ofs; e.kind = kind; e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic expAddr(input string name, input logic [63:0] a);
        expectAt(name, 0, 0, {81'd0, a});
    endtask

    task automatic expNextD(input string name, input logic [144:0] d);
        expectAt(name, 1, 1, d);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [144:0] act;
        case (e.kind)
            0:       act = {81'd0, imem_addr};
            1:       act = D;
            default: act = {144'd0, halted};
        endcase
        num_checks++;
        if (act !== e.val) begin
            num_fail++;
            $display("[TB] FAIL %s: actual %h required %h", e.name, act, e.val);
        end
    endtask

    // Monitor: retire every expectation that falls due in this cycle.
    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sb_q[i]) begin
            if (sb_q[i].due == cycle) checkOutput(sb_q[i]);
            else keep.push_back(sb_q[i]);
        end
        sb_q = keep;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h10;
        poke(12'h100, {64'h1122334455667788, 8'hF3, 8'h30}, 10);
        poke(12'h10B, {8'h00, 64'h0000000000000020, 8'h70}, 9);
        poke(12'h020, {8'h00, 64'h0000000000000080, 8'h70}, 9);
        poke(12'h080, {64'h0, 8'h01, 8'h60}, 2);
        poke(12'h029, {64'h0, 8'h12, 8'h20}, 2);
        poke(12'h400, {64'h0102030405060708, 8'hF5, 8'h30}, 10);
        poke(12'h40E, {72'h0, 8'hC0}, 1);
        poke(12'h601, {72'h0, 8'h00}, 1);

        s = idle(); s.rst_n = 1'b0;
        rst_n = 1'b0; F_stall = 0; D_stall = 0; D_bubble = 0; M_icode = 0; M_cnd = 0;
        M_valA = 0; W_icode = 0; W_valM = 0; W_err = 0; imem_error = 0;
        applyStimulus(s);
        applyStimulus(s);

        applyStimulus(idle());
        expAddr("reset_addr", 64'h100);
        expectAt("reset_D", 0, 1, bubbleD());
        expectAt("reset_halted", 0, 2, 145'd0);
        expNextD("irmovq_D", mkD(0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'h10A));

        applyStimulus(idle());
        expAddr("seq_addr_10A", 64'h10A);
        expNextD("nop_D", nopD(64'h10B));

        applyStimulus(idle());
        expAddr("seq_addr_10B", 64'h10B);
        expNextD("jmp20_D", mkD(0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h114));

        applyStimulus(idle());
        expAddr("pred_addr_20", 64'h20);
        expNextD("jmp80_D", mkD(0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h80, 64'h29));

        applyStimulus(idle());
        expAddr("pred_addr_80", 64'h80);
        expNextD("addq_D", mkD(0, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h82));

        s = idle(); s.m_icode = 4'h7; s.m_cnd = 1'b0; s.m_vala = 64'h29;
        s.w_icode = 4'h9; s.w_valm = 64'h400;
        applyStimulus(s);
        expAddr("mispredict_over_ret_addr", 64'h29);
        expNextD("rrmovq_D", mkD(0, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h2B));

        s = idle(); s.w_icode = 4'h9; s.w_valm = 64'h400;
        applyStimulus(s);
        expAddr("ret_addr", 64'h400);
        expNextD("irmovq2_D", mkD(0, 4'h3, 4'h0, 4'hF, 4'h5, 64'h0102030405060708, 64'h40A));

        s = idle(); s.d_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            expAddr("dstall_addr", 64'h40A + 64'(i));
            expNextD("dstall_hold_D", mkD(0, 4'h3, 4'h0, 4'hF, 4'h5, 64'h0102030405060708, 64'h40A));
        end

        s = idle(); s.d_stall = 1'b1; s.d_bubble = 1'b1;
        applyStimulus(s);
        expAddr("bubble_addr", 64'h40C);
        expNextD("bubble_over_stall_D", bubbleD());

        s = idle(); s.f_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            expAddr("fstall_addr", 64'h40D);
            expNextD("fstall_D", nopD(64'h40E));
        end

        applyStimulus(idle());
        expAddr("fstall_release_addr", 64'h40D);
        expNextD("fstall_release_D", nopD(64'h40E));

        applyStimulus(idle());
        expAddr("invalid_addr", 64'h40E);
        expNextD("invalid_D", mkD(1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h40F));

        applyStimulus(idle());
        expAddr("drain_addr", 64'h40F);
        expNextD("drain_bubble_D", bubbleD());

        s = idle(); s.m_icode = 4'h7; s.m_vala = 64'h500; s.w_err = 1'b1;
        applyStimulus(s);
        expAddr("drain_redirect_addr", 64'h500);
        expNextD("drain_redirect_D", nopD(64'h501));
        expectAt("redirect_beats_werr", 1, 2, 145'd0);

        s = idle(); s.imem_err = 1'b1;
        applyStimulus(s);
        expAddr("imem_err_addr", 64'h501);
        expNextD("imem_err_D", mkD(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h502));

        s = idle(); s.w_icode = 4'h9; s.w_valm = 64'h600;
        applyStimulus(s);
        expAddr("drain_ret_addr", 64'h600);
        expNextD("drain_ret_D", nopD(64'h601));

        applyStimulus(idle());
        expAddr("halt_addr", 64'h601);
        expNextD("halt_D", mkD(1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h602));
        expectAt("run_not_halted", 0, 2, 145'd0);

        applyStimulus(idle());
        expAddr("halt_drain_addr", 64'h602);
        expNextD("halt_drain_D", bubbleD());

        s = idle(); s.w_err = 1'b1;
        applyStimulus(s);
        expAddr("werr_addr", 64'h602);
        expNextD("werr_D", bubbleD());
        expectAt("halted_set", 1, 2, 145'd1);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(idle());
            expAddr("halted_addr_held", 64'h602);
            expNextD("halted_bubble_D", bubbleD());
            expectAt("halted_sticky", 1, 2, 145'd1);
        end

        s = idle(); s.rst_n = 1'b0; s.f_stall = 1'b1; s.d_stall = 1'b1;
        applyStimulus(s);

        applyStimulus(idle());
        expAddr("rereset_addr", 64'h100);
        expectAt("rereset_D", 0, 1, bubbleD());
        expectAt("rereset_halted", 0, 2, 145'd0);
        expNextD("rereset_irmovq_D", mkD(0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'h10A));

        for (int i = 0; i < 3; i++) applyStimulus(idle());
        @(negedge clk);
        #1;

        foreach (sb_q[i]) begin
            num_checks++;
            num_fail++;
            $display("[TB] FAIL %s: expectation never retired, required %h", sb_q[i].name, sb_q[i].val);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
